rx_pkt_framer: RTL and testbench

- Sits directly downstream of the receiver's DeFEC/CRC output (decoded byte stream, frame-start pulse, CRC verdict strobe).
- Buffers each decoded frame in a packet FIFO and releases it only after its CRC verdict arrives.
- Emits frames as AXI-Stream packets with a real tlast; frames with a CRC error, overflow or excessive length are dropped.
- Keeps saturating good-frame and dropped-frame counters for the status registers.

---
 rtl/rx_pkt_framer.sv | 207 ++++++++++++++++++++
 tb/tb_rx_pkt_framer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pkt_framer.sv
// rx_pkt_framer: CRC-gated packet FIFO between the DeFEC/CRC stage and AXI-Stream.
// Define RX_PKT_PASS_BAD_EN to commit CRC-failed frames with tuser set on tlast.
module rx_pkt_framer #(
    parameter int pADDR_W  = 11,
    parameter int pMAX_LEN = 1500,
    parameter int pCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        idat,
    input  logic              ival,
    input  logic              isop,
    input  logic              icrc_val,
    input  logic              icrc_err,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    input  logic              m_axis_tready,
    output logic [pCNT_W-1:0] o_frm_ok,
    output logic [pCNT_W-1:0] o_frm_drop,
    output logic              o_ovf
);

    localparam int LEN_W = $clog2(pMAX_LEN + 2);
`ifdef RX_PKT_PASS_BAD_EN
    localparam int TW = 2;
    localparam bit PASS = 1'b1;
`else
    localparam int TW = 1;
    localparam bit PASS = 1'b0;
`endif
    localparam int EW = TW + 8;
    localparam logic [pADDR_W:0] DEPTH = {1'b1, {pADDR_W{1'b0}}};
    localparam logic [pADDR_W:0] ONE = (pADDR_W+1)'(1);
    localparam logic [pADDR_W:0] TWO = (pADDR_W+1)'(2);
    localparam logic [LEN_W-1:0] MAXL = LEN_W'(pMAX_LEN);
    localparam logic [TW-1:0] TAG_MID = '0;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state;
    logic [EW-1:0] mem [2**pADDR_W];
    logic [pADDR_W:0] wr_ptr;
    logic [pADDR_W:0] cm_ptr;
    logic [pADDR_W:0] cm_q;
    logic [pADDR_W:0] rd_ptr;
    logic [7:0] stg;
    logic [LEN_W-1:0] len;
    logic drop;

    logic [pADDR_W:0] used;
    logic [pADDR_W:0] free;
    logic [pADDR_W:0] need;
    logic [pADDR_W:0] nwr;
    logic [pADDR_W-1:0] wa0;
    logic [pADDR_W-1:0] wa1;
    logic we0;
    logic we1;
    logic [EW-1:0] wd0;
    logic [EW-1:0] wd1;
    logic [TW-1:0] tag_last;
    logic [EW-1:0] rd_word;
    logic ovf_hit;
    logic commit;
    logic abort;
    logic fin;
    logic bad_pass;
    logic load;

    assign used = wr_ptr - rd_ptr;
    assign free = DEPTH - used;
    assign wa0 = wr_ptr[pADDR_W-1:0];
    assign wa1 = wa0 + 1'b1;
    assign nwr = we1 ? TWO : ONE;
    assign need = fin ? TWO : ONE;
    assign bad_pass = PASS && icrc_err;

`ifdef RX_PKT_PASS_BAD_EN
    assign tag_last = {bad_pass, 1'b1};
`else
    assign tag_last = 1'b1;
`endif

    // A verdict arriving with a data byte closes the frame with two writes.
    always_comb begin
        we0 = 1'b0;
        we1 = 1'b0;
        wd0 = {TAG_MID, stg};
        wd1 = {tag_last, idat};
        ovf_hit = 1'b0;
        commit = 1'b0;
        abort = 1'b0;
        fin = 1'b0;
        if (state == FILL) begin
            if (icrc_val) begin
                fin = ival && !isop;
                ovf_hit = !drop && (free < need);
                if (!drop && !ovf_hit && !(fin && len >= MAXL) &&
                    (!icrc_err || PASS)) begin
                    commit = 1'b1;
                    we0 = 1'b1;
                    we1 = fin;
                    if (!fin) wd0 = {tag_last, stg};
                end else begin
                    abort = 1'b1;
                end
            end else if (ival && isop) begin
                abort = 1'b1;
            end else if (ival && !drop) begin
                if (free == '0) ovf_hit = 1'b1;
                else we0 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wr_ptr <= '0;
            cm_ptr <= '0;
            stg <= '0;
            len <= '0;
            drop <= 1'b0;
            o_frm_ok <= '0;
            o_frm_drop <= '0;
            o_ovf <= 1'b0;
        end else begin
            if (abort) begin
                wr_ptr <= cm_ptr;
            end else if (commit) begin
                wr_ptr <= wr_ptr + nwr;
                cm_ptr <= wr_ptr + nwr;
            end else if (we0) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ovf_hit) o_ovf <= 1'b1;
            if (commit && !bad_pass && o_frm_ok != '1)
                o_frm_ok <= o_frm_ok + 1'b1;
            if ((abort || (commit && bad_pass)) && o_frm_drop != '1)
                o_frm_drop <= o_frm_drop + 1'b1;
            unique case (state)
                IDLE: begin
                    if (ival && isop) begin
                        stg <= idat;
                        len <= LEN_W'(1);
                        drop <= 1'b0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (ival && isop) begin
                        stg <= idat;
                        len <= LEN_W'(1);
                        drop <= 1'b0;
                    end else if (icrc_val) begin
                        state <= IDLE;
                    end else if (ival) begin
                        stg <= idat;
                        if (len <= MAXL) len <= len + 1'b1;
                        if (ovf_hit || len >= MAXL) drop <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end

    // Reader trails the commit pointer by one register stage.
    assign rd_word = mem[rd_ptr[pADDR_W-1:0]];
    assign load = (rd_ptr != cm_q) && (!m_axis_tvalid || m_axis_tready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cm_q <= '0;
            rd_ptr <= '0;
            m_axis_tdata <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
`ifdef RX_PKT_PASS_BAD_EN
            m_axis_tuser <= 1'b0;
`endif
        end else begin
            cm_q <= cm_ptr;
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
                m_axis_tdata <= rd_word[7:0];
                m_axis_tlast <= rd_word[8];
                m_axis_tvalid <= 1'b1;
`ifdef RX_PKT_PASS_BAD_EN
                m_axis_tuser <= rd_word[9];
`endif
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifndef RX_PKT_PASS_BAD_EN
    assign m_axis_tuser = 1'b0;
`endif

endmodule

// File: tb/tb_rx_pkt_framer.sv
// tb_rx_pkt_framer: scoreboard bench for rx_pkt_framer.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_rx_pkt_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  idat;
    logic        ival;
    logic        isop;
    logic        icrc_val;
    logic        icrc_err;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready;
    logic [15:0] o_frm_ok;
    logic [15:0] o_frm_drop;
    logic        o_ovf;

    logic [9:0] exp_q[$];
    logic [9:0] mon_e;
    int vectors = 0;
    int miscompares = 0;
    int nbeats = 0;
    int b0;
    int k;
    bit pass_bad;

    always #5 clk = ~clk;

    rx_pkt_framer dut (
        .clk(clk),
        .rst(rst),
        .idat(idat),
        .ival(ival),
        .isop(isop),
        .icrc_val(icrc_val),
        .icrc_err(icrc_err),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .o_frm_ok(o_frm_ok),
        .o_frm_drop(o_frm_drop),
        .o_ovf(o_ovf)
    );

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            nbeats++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_beat: actual %0h required none",
                         {m_axis_tuser, m_axis_tlast, m_axis_tdata});
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, mon_e);
            end
        end
    end

    task automatic send(input int n, input int base, input bit sop);
        for (int i = 0; i < n; i++) begin
            ival = 1'b1;
            isop = sop && (i == 0);
            idat = 8'(base + i);
            @(posedge clk);
            #1;
        end
        ival = 1'b0;
        isop = 1'b0;
    endtask

    task automatic verdict(input bit err);
        icrc_val = 1'b1;
        icrc_err = err;
        @(posedge clk);
        #1;
        icrc_val = 1'b0;
        icrc_err = 1'b0;
    endtask

    task automatic expect_frame(input int n, input int base, input bit user);
        for (int i = 0; i < n; i++)
            exp_q.push_back({user && (i == n - 1), i == n - 1, 8'(base + i)});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", n < budget, 1);
    endtask

    initial begin
`ifdef RX_PKT_PASS_BAD_EN
        pass_bad = 1'b1;
`else
        pass_bad = 1'b0;
`endif
        rst = 1'b1;
        ival = 1'b0;
        isop = 1'b0;
        idat = '0;
        icrc_val = 1'b0;
        icrc_err = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser,
            m_axis_tdata, o_frm_ok, o_frm_drop, o_ovf}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 64-byte good frame, latency and ordering
        expect_frame(64, 0, 1'b0);
        send(64, 0, 1'b1);
        verdict(1'b0);
        k = 0;
        while (!m_axis_tvalid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t1_latency", k, 2);
        drain(200);
        chk("t1_ok", o_frm_ok, 1);
        chk("t1_drop", o_frm_drop, 0);

        // same frame with CRC error
        b0 = nbeats;
        if (pass_bad) expect_frame(64, 0, 1'b1);
        send(64, 0, 1'b1);
        verdict(1'b1);
        repeat (4) @(posedge clk);
        #1;
        drain(200);
        chk("t2_beats", nbeats - b0, pass_bad ? 64 : 0);
        chk("t2_ok", o_frm_ok, 1);
        chk("t2_drop", o_frm_drop, 1);

        // verdict of A coincides with sop of B
        b0 = nbeats;
        expect_frame(10, 'h10, 1'b0);
        expect_frame(10, 'h40, 1'b0);
        send(10, 'h10, 1'b1);
        ival = 1'b1;
        isop = 1'b1;
        idat = 8'h40;
        icrc_val = 1'b1;
        @(posedge clk);
        #1;
        icrc_val = 1'b0;
        isop = 1'b0;
        send(9, 'h41, 1'b0);
        verdict(1'b0);
        drain(200);
        chk("t3_beats", nbeats - b0, 20);
        chk("t3_ok", o_frm_ok, 3);

        // length limit
        send(1501, 0, 1'b1);
        verdict(1'b0);
        expect_frame(1500, 'h55, 1'b0);
        send(1500, 'h55, 1'b1);
        verdict(1'b0);
        drain(3000);
        chk("t4_drop", o_frm_drop, 2);
        chk("t4_ok", o_frm_ok, 4);

        // overflow with a stalled sink
        m_axis_tready = 1'b0;
        expect_frame(1000, 'h01, 1'b0);
        send(1000, 'h01, 1'b1);
        verdict(1'b0);
        expect_frame(1000, 'h81, 1'b0);
        send(1000, 'h81, 1'b1);
        verdict(1'b0);
        send(1000, 'hC3, 1'b1);
        verdict(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_ovf", o_ovf, 1);
        chk("t5_ok", o_frm_ok, 6);
        chk("t5_drop", o_frm_drop, 3);
        b0 = nbeats;
        m_axis_tready = 1'b1;
        drain(2500);
        chk("t5_beats", nbeats - b0, 2000);

        // reset in the middle of a frame with data held at the output
        m_axis_tready = 1'b0;
        expect_frame(8, 'hA5, 1'b0);
        send(8, 'hA5, 1'b1);
        verdict(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_hold_valid", m_axis_tvalid, 1);
        chk("t6_hold_data", m_axis_tdata, 'hA5);
        send(20, 'h33, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser,
            m_axis_tdata, o_frm_ok, o_frm_drop, o_ovf}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_axis_tready = 1'b1;
        b0 = nbeats;
        expect_frame(16, 'h70, 1'b0);
        send(16, 'h70, 1'b1);
        verdict(1'b0);
        drain(200);
        chk("t6_beats", nbeats - b0, 16);
        chk("t6_ok", o_frm_ok, 1);
        chk("t6_ovf", o_ovf, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
